// File: rtl/ppt_pkg.sv
// ppt_pkg: shared definitions for the pulsed-plasma-thruster sequencer.
//   - ppt_state_e : sequencer FSM states
//   - DEF_*_W     : default field widths for clk_div, period/width, count
package ppt_pkg;

  localparam int unsigned DEF_DIV_W  = 5;
  localparam int unsigned DEF_TIME_W = 14;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FIRE   = 2'd2,
    DONE   = 2'd3
  } ppt_state_e;

endpackage

// File: rtl/ppt_prescaler.sv
// ppt_prescaler: programmable time base for the PPT sequencer.
// Counts 0 .. 2^(clk_div+1)-1 and flags tick while at the terminal value.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear (start of a run)
//   en        : count enable
//   clk_div   : latched divider select
//   tick      : high for one cycle per prescaled period
module ppt_prescaler #(
  parameter int unsigned DIV_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  localparam int unsigned PW = 2 ** DIV_W;

  logic [PW-1:0]    cnt;
  logic [PW-1:0]    all_ones;
  logic [PW-1:0]    term;
  logic [DIV_W-1:0] shamt;

  // terminal = 2^(clk_div+1)-1, built as a right-shifted all-ones mask
  always_comb begin
    all_ones = '1;
    shamt    = DIV_W'(PW - 1) - clk_div;
    term     = all_ones >> shamt;
    tick     = en & (cnt == term);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/ppt_sequencer.sv
// ppt_sequencer: pulsed-plasma-thruster trigger timing engine.
// Latches the configuration on a rising run_ppt and fires `count` trigger
// pulses, each width_eff ticks high every `period` ticks.
// Optional feature macro: PPT_CHARGE_EN (adds charge_en port and CHARGE state).
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   clk_div    : tick period = 2^(clk_div+1) clk cycles
//   period     : firing period in ticks
//   width      : trigger high time in ticks (clamped to period-1)
//   count      : firings per run
//   run_ppt    : run level from the register map
//   pulse_out  : thruster trigger
//   count_done : firings completed in the current or last run
//   done       : run completed normally
//   busy       : run in progress (CHARGE or FIRE)
//   charge_en  : capacitor charge enable (PPT_CHARGE_EN only)
module ppt_sequencer
  import ppt_pkg::*;
#(
  parameter int unsigned DIV_W  = DEF_DIV_W,
  parameter int unsigned TIME_W = DEF_TIME_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [TIME_W-1:0] period,
  input  logic [TIME_W-1:0] width,
  input  logic [CNT_W-1:0]  count,
  input  logic              run_ppt,
  output logic              pulse_out,
  output logic [CNT_W-1:0]  count_done,
  output logic              done,
  output logic              busy
`ifdef PPT_CHARGE_EN
  ,
  output logic              charge_en
`endif
);

  ppt_state_e        state;
  logic              run_q;
  logic [DIV_W-1:0]  div_q;
  logic [TIME_W-1:0] period_q;
  logic [TIME_W-1:0] width_q;
  logic [CNT_W-1:0]  count_q;
  logic [TIME_W-1:0] tick_cnt;

  logic              tick;
  logic              start;
  logic              cfg_bad;
  logic [TIME_W-1:0] period_m1_in;
  logic [TIME_W-1:0] width_eff_in;
  logic [TIME_W-1:0] tick_inc;
  logic              period_end;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    start        = (state == IDLE) & run_ppt & ~run_q;
    cfg_bad      = (count == '0) | (period < TIME_W'(2)) | (width == '0);
    period_m1_in = period - TIME_W'(1);
    width_eff_in = (width > period_m1_in) ? period_m1_in : width;
    tick_inc     = tick_cnt + TIME_W'(1);
    period_end   = tick & (tick_cnt == period_q - TIME_W'(1));
    count_next   = count_done + CNT_W'(1);
    busy         = (state == FIRE) | (state == CHARGE);
    done         = (state == DONE);
  end

`ifdef PPT_CHARGE_EN
  always_comb begin
    charge_en = (state == CHARGE) | ((state == FIRE) & ~pulse_out);
  end
`endif

  ppt_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (start),
    .en      (busy),
    .clk_div (div_q),
    .tick    (tick)
  );

  // pulse_out is computed from the next tick_cnt value so it is high in the
  // first cycle after start and tracks tick_cnt without an extra cycle lag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      div_q      <= '0;
      period_q   <= '0;
      width_q    <= '0;
      count_q    <= '0;
      tick_cnt   <= '0;
      count_done <= '0;
      pulse_out  <= 1'b0;
    end else begin
      run_q <= run_ppt;
      case (state)
        IDLE: begin
          pulse_out <= 1'b0;
          if (start) begin
            div_q      <= clk_div;
            period_q   <= period;
            width_q    <= width_eff_in;
            count_q    <= count;
            tick_cnt   <= '0;
            count_done <= '0;
            if (cfg_bad) begin
              state <= DONE;
            end else begin
`ifdef PPT_CHARGE_EN
              state     <= CHARGE;
`else
              state     <= FIRE;
              pulse_out <= 1'b1;
`endif
            end
          end
        end
`ifdef PPT_CHARGE_EN
        CHARGE: begin
          pulse_out <= 1'b0;
          if (!run_ppt) begin
            state <= IDLE;
          end else if (tick) begin
            if (period_end) begin
              tick_cnt  <= '0;
              state     <= FIRE;
              pulse_out <= 1'b1;
            end else begin
              tick_cnt <= tick_inc;
            end
          end
        end
`endif
        FIRE: begin
          if (!run_ppt) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
          end else if (tick) begin
            if (period_end) begin
              tick_cnt   <= '0;
              count_done <= count_next;
              if (count_next == count_q) begin
                state     <= DONE;
                pulse_out <= 1'b0;
              end else begin
                pulse_out <= 1'b1;
              end
            end else begin
              tick_cnt  <= tick_inc;
              pulse_out <= (tick_inc < width_q);
            end
          end
        end
        DONE: begin
          pulse_out <= 1'b0;
          if (!run_ppt) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          pulse_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppt_sequencer.sv
module tb_ppt_sequencer;

  localparam int unsigned DIV_W  = 5;
  localparam int unsigned TIME_W = 14;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rstn;
  logic [DIV_W-1:0]  clk_div;
  logic [TIME_W-1:0] period;
  logic [TIME_W-1:0] width;
  logic [CNT_W-1:0]  count;
  logic              run_ppt;
  logic              pulse_out;
  logic [CNT_W-1:0]  count_done;
  logic              done;
  logic              busy;
`ifdef PPT_CHARGE_EN
  logic              charge_en;
`endif

  int vectors = 0;
  int errors  = 0;

  ppt_sequencer #(
    .DIV_W (DIV_W),
    .TIME_W(TIME_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clk_div   (clk_div),
    .period    (period),
    .width     (width),
    .count     (count),
    .run_ppt   (run_ppt),
    .pulse_out (pulse_out),
    .count_done(count_done),
    .done      (done),
    .busy      (busy)
`ifdef PPT_CHARGE_EN
    ,
    .charge_en (charge_en)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int p, input int w, input int c);
    clk_div = DIV_W'(d);
    period  = TIME_W'(p);
    width   = TIME_W'(w);
    count   = CNT_W'(c);
  endtask

  task automatic end_run();
    run_ppt = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({pulse_out, done, busy} !== 3'b000 || count_done !== '0) begin
      errors++;
      $display("FAIL reset pulse/done/busy=%b%b%b count_done=%0d required 000/0",
               pulse_out, done, busy, count_done);
    end
`ifdef PPT_CHARGE_EN
    vectors++;
    if (charge_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_charge_en got %b required 0", charge_en);
    end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  // clk_div=0 (2 clk/tick), period 4, width 1, count 3
  task automatic test_basic();
    logic exp;
    logic prev;
    int   rises;
    prev  = 1'b0;
    rises = 0;
    set_cfg(0, 4, 1, 3);
    run_ppt = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      exp = ((k - 1) / 8 < 3) && ((k - 1) % 8 < 2);
      vectors++;
      if (pulse_out !== exp) begin
        errors++;
        $display("FAIL basic_pulse k=%0d got %b required %b", k, pulse_out, exp);
      end
      if (pulse_out && !prev) rises++;
      prev = pulse_out;
      if (k == 24) begin
        vectors++;
        if (done !== 1'b0 || count_done !== 8'd2 || busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_pre_done done=%b cnt=%0d busy=%b required 0/2/1",
                   done, count_done, busy);
        end
      end
      if (k == 25) begin
        vectors++;
        if (done !== 1'b1 || count_done !== 8'd3 || busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_done done=%b cnt=%0d busy=%b required 1/3/0",
                   done, count_done, busy);
        end
      end
    end
    vectors++;
    if (rises != 3) begin
      errors++;
      $display("FAIL basic_rises got %0d required 3", rises);
    end
    run_ppt = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0 || count_done !== 8'd3) begin
      errors++;
      $display("FAIL basic_idle done=%b cnt=%0d required 0/3", done, count_done);
    end
    step();
  endtask

  // width 10 clamps to period-1 = 3 ticks -> 6 clk high, 2 clk low
  task automatic test_width_clamp();
    logic exp;
    set_cfg(0, 4, 10, 2);
    run_ppt = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      exp = ((k - 1) / 8 < 2) && ((k - 1) % 8 < 6);
      vectors++;
      if (pulse_out !== exp) begin
        errors++;
        $display("FAIL clamp_pulse k=%0d got %b required %b", k, pulse_out, exp);
      end
    end
    vectors++;
    if (done !== 1'b1 || count_done !== 8'd2) begin
      errors++;
      $display("FAIL clamp_done done=%b cnt=%0d required 1/2", done, count_done);
    end
    end_run();
  endtask

  task automatic test_invalid_cfg();
    for (int v = 0; v < 3; v++) begin
      if (v == 0) set_cfg(0, 4, 1, 0);
      else if (v == 1) set_cfg(0, 1, 1, 3);
      else set_cfg(0, 4, 0, 3);
      run_ppt = 1'b1;
      step();
      vectors++;
      if (done !== 1'b1 || count_done !== 8'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL invalid_%0d done=%b cnt=%0d busy=%b required 1/0/0",
                 v, done, count_done, busy);
      end
      for (int k = 0; k < 3; k++) begin
        step();
        vectors++;
        if (pulse_out !== 1'b0) begin
          errors++;
          $display("FAIL invalid_pulse_%0d got %b required 0", v, pulse_out);
        end
      end
      end_run();
      // leave a nonzero count_done behind so the next case is meaningful
      if (v < 2) begin
        set_cfg(0, 2, 1, 1);
        run_ppt = 1'b1;
        repeat (6) step();
        end_run();
      end
    end
  endtask

  // abort during the 2nd firing of a count=5 run
  task automatic test_abort();
    set_cfg(0, 4, 1, 5);
    run_ppt = 1'b1;
    repeat (9) step();
    vectors++;
    if (pulse_out !== 1'b1 || count_done !== 8'd1) begin
      errors++;
      $display("FAIL abort_pre pulse=%b cnt=%0d required 1/1", pulse_out, count_done);
    end
    run_ppt = 1'b0;
    step();
    vectors++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count_done !== 8'd1) begin
      errors++;
      $display("FAIL abort pulse=%b busy=%b done=%b cnt=%0d required 0/0/0/1",
               pulse_out, busy, done, count_done);
    end
    step();
  endtask

  // config changes after start must not alter the waveform
  task automatic test_midrun_change();
    logic exp;
    set_cfg(1, 4, 1, 2);
    run_ppt = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      if (k == 1) set_cfg(0, 9, 5, 7);
      exp = ((k - 1) / 16 < 2) && ((k - 1) % 16 < 4);
      vectors++;
      if (pulse_out !== exp) begin
        errors++;
        $display("FAIL midrun_pulse k=%0d got %b required %b", k, pulse_out, exp);
      end
      if (k == 32 || k == 36) begin
        vectors++;
        if (done !== (k == 36)) begin
          errors++;
          $display("FAIL midrun_done k=%0d got %b required %b", k, done, (k == 36));
        end
      end
    end
    vectors++;
    if (count_done !== 8'd2) begin
      errors++;
      $display("FAIL midrun_count got %0d required 2", count_done);
    end
    run_ppt = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release done got %b required 0", done);
    end
    step();
    run_ppt = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b1 || count_done !== 8'd0) begin
      errors++;
      $display("FAIL midrun_restart busy=%b cnt=%0d required 1/0", busy, count_done);
    end
    end_run();
  endtask

`ifdef PPT_CHARGE_EN
  // period 3 ticks of charge (6 clk) before the first pulse
  task automatic test_charge();
    set_cfg(0, 3, 1, 1);
    run_ppt = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      vectors++;
      if (charge_en !== (k <= 6) || pulse_out !== (k == 7)) begin
        errors++;
        $display("FAIL charge k=%0d charge_en=%b pulse=%b required %b/%b",
                 k, charge_en, pulse_out, (k <= 6), (k == 7));
      end
    end
    end_run();
  endtask
`endif

  task automatic test_reset_midrun();
    set_cfg(0, 4, 2, 5);
    run_ppt = 1'b1;
    repeat (9) step();
    vectors++;
    if (pulse_out !== 1'b1 || count_done !== 8'd1) begin
      errors++;
      $display("FAIL rst_pre pulse=%b cnt=%0d required 1/1", pulse_out, count_done);
    end
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count_done !== 8'd0) begin
      errors++;
      $display("FAIL rst_async pulse=%b busy=%b done=%b cnt=%0d required 0/0/0/0",
               pulse_out, busy, done, count_done);
    end
    run_ppt = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  initial begin
    rstn    = 1'b0;
    run_ppt = 1'b0;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_width_clamp();
    test_invalid_cfg();
    test_abort();
    test_midrun_change();
`ifdef PPT_CHARGE_EN
    test_charge();
`endif
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
